// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC unit owning the fetch PC register.
// Selects sequential, branch, jump and jump-register targets; a valid/ready
// handshake gates PC advance and redirects seen during a stall are held.
// Optional feature macro: PC_RAS_EN (return-address stack of RAS_DEPTH entries).
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              link,
    input  logic              ret,
    output logic              misaligned,
    output logic              ras_empty
);

    localparam int unsigned EXT_W = ADDR_W - 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pc_valid_d;
    logic              active;
    logic              redir;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] jr_eff_tgt;
    logic [ADDR_W-1:0] tgt;
    logic              ras_pop;
    logic              misaligned_d;

    // Candidate targets, all relative to the current (frozen-while-stalled) pc
    always_comb begin
        pc4     = pc + ADDR_W'(4);
        br_tgt  = pc4 + ({{EXT_W{branch_off[15]}}, branch_off} << 2);
        jmp_tgt = {pc4[ADDR_W-1:28], jump_idx, 2'b00};
        jr_tgt  = {jr_target[ADDR_W-1:2], 2'b00};
    end

    assign active = (state_q != BOOT);
    assign redir  = jr | jump | branch_taken;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wp, ras_wp_d;
    logic [CNT_W-1:0]  ras_cnt, ras_cnt_d;
    logic [PTR_W-1:0]  ras_top;
    logic              ras_push;

    assign ras_top    = (ras_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wp - PTR_W'(1);
    assign ras_push   = active & link & (jr | jump);
    assign ras_pop    = active & jr & ret & (ras_cnt != '0);
    assign jr_eff_tgt = ras_pop ? ras_mem[ras_top] : jr_tgt;

    // Stack pointer/count update; push+pop replaces the top in place
    always_comb begin
        ras_wp_d  = ras_wp;
        ras_cnt_d = ras_cnt;
        if (ras_push && !ras_pop) begin
            ras_wp_d = (ras_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wp + PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt + CNT_W'(1);
            end
        end else if (ras_pop && !ras_push) begin
            ras_wp_d  = ras_top;
            ras_cnt_d = ras_cnt - CNT_W'(1);
        end
    end

    // Return-address storage; oldest entry is overwritten when full
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[(ras_push && ras_pop) ? ras_top : ras_wp] <= pc4;
        end
    end

    // Stack pointer, count and registered empty flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_wp    <= '0;
            ras_cnt   <= '0;
            ras_empty <= 1'b1;
        end else begin
            ras_wp    <= ras_wp_d;
            ras_cnt   <= ras_cnt_d;
            ras_empty <= (ras_cnt_d == '0);
        end
    end
`else
    logic unused_ras;

    assign ras_pop    = 1'b0;
    assign jr_eff_tgt = jr_tgt;
    assign ras_empty  = 1'b1;
    assign unused_ras = &{1'b0, link, ret, RAS_DEPTH != 0};
`endif

    // Priority select: jr > jump > branch
    always_comb begin
        if (jr) begin
            tgt = jr_eff_tgt;
        end else if (jump) begin
            tgt = jmp_tgt;
        end else begin
            tgt = br_tgt;
        end
    end

    // Next-state, next-pc and pending-redirect logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        pend_d       = pend_q;
        misaligned_d = active & jr & ~ras_pop & (|jr_target[1:0]);
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (fetch_ready) begin
                    pc_d = redir ? tgt : pc4;
                end else if (redir) begin
                    pend_d  = tgt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pend_d = tgt;
                end
                if (fetch_ready) begin
                    pc_d    = redir ? tgt : pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        pc_valid_d = (state_d != BOOT);
    end

    // State, pc and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc         <= RESET_PC;
            pend_q     <= '0;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            pend_q     <= pend_d;
            pc_valid   <= pc_valid_d;
            misaligned <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default parameters).
// Expected pc/valid/misaligned/ras_empty are queued when stimulus is driven
// and popped after the following clock edge.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_ready;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              branch_taken;
    logic [15:0]       branch_off;
    logic              jump;
    logic [25:0]       jump_idx;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              link;
    logic              ret;
    logic              misaligned;
    logic              ras_empty;

    typedef struct {
        logic        fr;
        logic        br;
        logic [15:0] boff;
        logic        jmp;
        logic [25:0] jidx;
        logic        jr;
        logic [31:0] jt;
        logic        lk;
        logic        rt;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic        empty;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0),
        .RAS_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .branch_taken(branch_taken),
        .branch_off  (branch_off),
        .jump        (jump),
        .jump_idx    (jump_idx),
        .jr          (jr),
        .jr_target   (jr_target),
        .link        (link),
        .ret         (ret),
        .misaligned  (misaligned),
        .ras_empty   (ras_empty)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic fr, logic br, logic [15:0] boff, logic jmp,
                                logic [25:0] jidx, logic j, logic [31:0] jt,
                                logic lk, logic rt);
        stim_t s;
        s.fr = fr; s.br = br; s.boff = boff; s.jmp = jmp; s.jidx = jidx;
        s.jr = j; s.jt = jt; s.lk = lk; s.rt = rt;
        return s;
    endfunction

    function automatic exp_t E(logic [31:0] p, logic v, logic m, logic em);
        exp_t e;
        e.pc = p; e.valid = v; e.mis = m; e.empty = em;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        fetch_ready  = s.fr;
        branch_taken = s.br;
        branch_off   = s.boff;
        jump         = s.jmp;
        jump_idx     = s.jidx;
        jr           = s.jr;
        jr_target    = s.jt;
        link         = s.lk;
        ret          = s.rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
        rst_n = 1'b0;
        apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        n_cmp++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || misaligned !== 1'b0 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: pc=%h valid=%b mis=%b empty=%b, expected pc=0 valid=0 mis=0 empty=1",
                     pc, pc_valid, misaligned, ras_empty);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (pc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_valid: pc_valid=%b, expected 0", pc_valid);
        end
        for (int i = 0; i < 4; i++) begin
            st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
            ex.push_back(E(32'(i * 4), 1, 0, 1));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL reset_seq step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    task automatic test_branch_jump();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h100, 0, 0));              ex.push_back(E(32'h100, 1, 0, 1));
        st.push_back(S(1, 1, 16'hFFFE, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'h0FC, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h100, 0, 0));              ex.push_back(E(32'h100, 1, 0, 1));
        st.push_back(S(1, 1, 16'hFFFE, 1, 26'h40, 0, 0, 0, 0));        ex.push_back(E(32'h100, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));                    ex.push_back(E(32'h104, 1, 0, 1));
        st.push_back(S(1, 1, 16'h0010, 1, 26'h40, 1, 32'h500, 0, 0));  ex.push_back(E(32'h500, 1, 0, 1));
        st.push_back(S(1, 1, 16'h0003, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'h510, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL branch_jump step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    task automatic test_stall_hold();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h200, 0, 0));   ex.push_back(E(32'h200, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 1, 32'h1003, 0, 0));  ex.push_back(E(32'h200, 1, 1, 1));
        st.push_back(S(0, 1, 16'h0001, 0, 0, 0, 0, 0, 0));  ex.push_back(E(32'h200, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h208, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h20C, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h20C, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h210, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 1, 32'h300, 0, 0));   ex.push_back(E(32'h210, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h404, 0, 0));   ex.push_back(E(32'h404, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h408, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 1, 32'h600, 0, 0));   ex.push_back(E(32'h408, 1, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h408, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));         ex.push_back(E(32'h600, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL stall_hold step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'hFFFFFFF8, 0, 0));  ex.push_back(E(32'hFFFFFFF8, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'hFFFFFFFC, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'h00000000, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));             ex.push_back(E(32'h00000004, 1, 0, 1));
        st.push_back(S(1, 1, 16'hFFFD, 0, 0, 0, 0, 0, 0));      ex.push_back(E(32'hFFFFFFFC, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL wrap step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    task automatic test_ras();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
`ifdef PC_RAS_EN
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h10, 0, 0));     ex.push_back(E(32'h10, 1, 0, 1));
        st.push_back(S(1, 0, 0, 1, 26'h08, 0, 0, 1, 0));     ex.push_back(E(32'h20, 1, 0, 0));
        st.push_back(S(1, 0, 0, 1, 26'h0C, 0, 0, 1, 0));     ex.push_back(E(32'h30, 1, 0, 0));
        st.push_back(S(1, 0, 0, 1, 26'h10, 0, 0, 1, 0));     ex.push_back(E(32'h40, 1, 0, 0));
        st.push_back(S(1, 0, 0, 1, 26'h14, 0, 0, 1, 0));     ex.push_back(E(32'h50, 1, 0, 0));
        st.push_back(S(1, 0, 0, 1, 26'h100, 0, 0, 1, 0));    ex.push_back(E(32'h400, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h802, 0, 1));    ex.push_back(E(32'h54, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h802, 0, 1));    ex.push_back(E(32'h44, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h802, 0, 1));    ex.push_back(E(32'h34, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h802, 0, 1));    ex.push_back(E(32'h24, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h802, 0, 1));    ex.push_back(E(32'h800, 1, 1, 1));
        st.push_back(S(1, 0, 0, 1, 26'h100, 0, 0, 1, 0));    ex.push_back(E(32'h400, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h900, 1, 1));    ex.push_back(E(32'h804, 1, 0, 0));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h900, 0, 1));    ex.push_back(E(32'h404, 1, 0, 1));
`else
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h900, 1, 1));    ex.push_back(E(32'h900, 1, 0, 1));
        st.push_back(S(1, 0, 0, 1, 26'h80, 0, 0, 1, 0));     ex.push_back(E(32'h200, 1, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 1, 32'h123, 0, 1));    ex.push_back(E(32'h120, 1, 1, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 1));          ex.push_back(E(32'h124, 1, 0, 1));
`endif
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL ras step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    // Random back-to-back traffic checked against a small behavioural model
    task automatic test_back_to_back();
        exp_t        e;
        stim_t       s;
        logic [31:0] m_pc;
        logic [31:0] m_pend;
        logic        m_hold;
        logic [31:0] pc4;
        logic [31:0] tgt;
        logic        rd;
        rst_n = 1'b0;
        apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        tick();
        m_pc   = 32'h0;
        m_pend = 32'h0;
        m_hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            s = S($urandom_range(3) != 0, $urandom_range(5) == 0, 16'($urandom),
                  $urandom_range(6) == 0, 26'($urandom), $urandom_range(6) == 0,
                  $urandom, 0, 0);
            pc4 = m_pc + 32'd4;
            rd  = s.jr | s.jmp | s.br;
            if (s.jr) begin
                tgt = {s.jt[31:2], 2'b00};
            end else if (s.jmp) begin
                tgt = {pc4[31:28], s.jidx, 2'b00};
            end else begin
                tgt = pc4 + {{14{s.boff[15]}}, s.boff, 2'b00};
            end
            if (!m_hold) begin
                if (s.fr) begin
                    m_pc = rd ? tgt : pc4;
                end else if (rd) begin
                    m_pend = tgt;
                    m_hold = 1'b1;
                end
            end else begin
                if (s.fr) begin
                    m_pc   = rd ? tgt : m_pend;
                    m_hold = 1'b0;
                end else if (rd) begin
                    m_pend = tgt;
                end
            end
            apply(s);
            sb.push_back(E(m_pc, 1, s.jr & (s.jt[1:0] != 2'b00), 1));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t  e;
        stim_t st[$];
        exp_t  ex[$];
        apply(S(1, 0, 0, 0, 0, 1, 32'h300, 0, 0));
        tick();
        apply(S(0, 0, 0, 0, 0, 1, 32'h400, 0, 0));
        tick();
        n_cmp++;
        if (pc !== 32'h300) begin
            n_bad++;
            $display("FAIL mid_hold_setup: pc=%h, expected 300", pc);
        end
        apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_hold_reset: pc=%h valid=%b empty=%b, expected pc=0 valid=0 empty=1",
                     pc, pc_valid, ras_empty);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
            ex.push_back(E(32'(i * 4), 1, 0, 1));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (pc !== e.pc || pc_valid !== e.valid || misaligned !== e.mis || ras_empty !== e.empty) begin
                n_bad++;
                $display("FAIL mid_hold_restart step %0d: pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                         i, pc, pc_valid, misaligned, ras_empty, e.pc, e.valid, e.mis, e.empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_stall_hold();
        test_wrap();
        test_ras();
        test_back_to_back();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
